uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Receive-side byte buffer sitting directly downstream of the UART receiver.
- Captures each byte the receiver reports with its one-cycle valid strobe and stores it in a power-of-two circular FIFO.
- Presents stored bytes to the consumer over a valid/ready handshake.
- Reports fill level, full/empty status and a sticky overrun flag, so software-facing logic can drain bytes at its own pace without losing them silently.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries; legal range 1..8.

Ports:
- clk  input  1  clock; all logic rising-edge.
- rst_n  input  1  reset, synchronous, active-low.
- rx_data  input  8  byte from UART receiver.
- rx_valid  input  1  push strobe; each cycle high is one push of rx_data.
- out_data  output  8  oldest stored byte.
- out_valid  output  1  FIFO non-empty; out_data meaningful.
- out_ready  input  1  consumer accepts out_data this cycle.
- level  output  DEPTH_LOG2+1  number of stored bytes, 0..2**DEPTH_LOG2.
- full  output  1  level == 2**DEPTH_LOG2.
- empty  output  1  level == 0.
- overrun  output  1  sticky; a byte was dropped.
- overrun_clr  input  1  clears overrun.

Behaviour:
- Reset (rst_n low at a clock edge):
  - Read/write pointers and level go to 0; out_valid=0, empty=1, full=0, overrun=0.
  - Stored contents are discarded and need not be cleared.
  - Reset takes priority over every other input. A reset mid-stream drops all queued bytes, and the first post-reset push lands at entry 0.
- Storage:
  - Array of 2**DEPTH_LOG2 x 8-bit registers, plus read and write pointers of DEPTH_LOG2+1 bits each. The MSB distinguishes full from empty; pointers wrap naturally.
  - level = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1).
- Pop:
  - A pop occurs in a cycle where out_valid && out_ready; rd_ptr increments at that edge.
  - out_ready while empty has no effect.
- Push:
  - A push is requested in a cycle where rx_valid=1.
  - The push is accepted if !full, or if full and a pop occurs in the same cycle. An accepted push writes rx_data at wr_ptr, and wr_ptr increments at that edge.
  - A push requested while full with no simultaneous pop is dropped. Pointers and contents are unchanged, and overrun is set at that edge.
- Simultaneous push and pop: level is unchanged and both pointers advance.
- Empty with push: no pop is possible that cycle, so level goes 0 -> 1.
- Latency:
  - A byte pushed at edge N is visible at edge N+1: out_valid=1 and out_data = that byte, read combinationally from mem[rd_ptr].
  - There is no bypass; a byte is never presented in the same cycle it is pushed.
- Output stability: out_data is don't-care while out_valid=0. While out_valid=1 and no pop occurs, out_data holds stable.
- Status: level, full, empty and out_valid are derived from the registered pointers only; there are no combinational paths from rx_valid or out_ready.
- Overrun:
  - Set by a dropped push; cleared by overrun_clr.
  - If a drop and overrun_clr occur in the same cycle, set wins and overrun=1.
  - Overrun has no effect on data flow.
- Ordering: bytes leave strictly in arrival order. Dropped bytes never appear at the output.

Test Plan:
- Reset then idle 5 cycles -> out_valid=0, empty=1, full=0, level=0, overrun=0.
- Push 0x41, 0x42, 0x43 on separate cycles with out_ready=0 -> level=3; out_data=0x41. Then out_ready=1 for 3 cycles -> 0x41, 0x42, 0x43 popped in order, empty=1 afterwards.
- DEPTH_LOG2=4: push 0x00..0x0F -> full=1, level=16. Push 0xAA with no pop -> dropped, overrun=1, level=16. Drain all 16 -> values 0x00..0x0F, no 0xAA.
- Full FIFO with rx_valid=1 (0x55) and out_ready=1 in the same cycle -> level stays 16, overrun stays 0, and 0x55 emerges last after the 16 prior bytes.
- Overrun set, then overrun_clr=1 in the same cycle as another dropped push -> overrun=1. overrun_clr alone next cycle -> overrun=0.
- Push 40 bytes with interleaved pops so the pointers wrap twice -> output sequence matches input exactly. Then assert rst_n=0 mid-stream with level=5 -> next cycle level=0, out_valid=0; the next push is output as the first byte.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Each rx_valid strobe pushes one byte into a power-of-two circular FIFO.
// The consumer drains bytes over a valid/ready handshake. Status outputs
// (level, full, empty) and out_valid come from the registered pointers only.
// A push that arrives while the FIFO is full, with no pop in the same cycle,
// is dropped and raises the sticky overrun flag.
module uart_rx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty,
  output logic                  overrun,
  input  logic                  overrun_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [7:0]            mem [DEPTH];

  logic                  pop;
  logic                  push;
  logic                  drop;
  logic [DEPTH_LOG2-1:0] wr_idx;
  logic [DEPTH_LOG2-1:0] rd_idx;

  assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
  assign rd_idx = rd_ptr[DEPTH_LOG2-1:0];

  // Fill level wraps naturally with the pointer width.
  assign level     = wr_ptr - rd_ptr;
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (level == DEPTH_CNT);
  assign out_valid = !empty;

  // Oldest stored byte is read straight out of the array; no bypass path.
  assign out_data  = mem[rd_idx];

  // A full FIFO can still accept a byte when the consumer frees a slot
  // in the same cycle.
  assign pop  = out_valid && out_ready;
  assign push = rx_valid && (!full || pop);
  assign drop = rx_valid && full && !pop;

  // Pointer registers: reset returns both to entry 0, discarding contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Byte storage: data only, never reset; gated by reset so a push during
  // reset cannot land anywhere meaningful.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_idx] <= rx_data;
    end
  end

  // Sticky overrun: a dropped byte sets it and wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue-based reference model is
// compared against the DUT every cycle, alongside directed scenarios with
// literal expectations and a randomized traffic phase.
module tb_uart_rx_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_valid = 1'b0;
  logic [7:0]          out_data;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DEPTH_LOG2:0] level;
  logic                full;
  logic                empty;
  logic                overrun;
  logic                overrun_clr = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Reference model: a queue of stored bytes and the overrun flag.
  logic [7:0] q[$];
  bit         m_ovr = 1'b0;
  // Bytes the DUT actually handed over, for directed ordering checks.
  logic [7:0] popped[$];

  uart_rx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level(level),
    .full(full),
    .empty(empty),
    .overrun(overrun),
    .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model update at the active edge using the inputs held during the cycle.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ovr <= 1'b0;
    end else begin
      if (rx_valid && q.size() == DEPTH && !out_ready) m_ovr <= 1'b1;
      else if (overrun_clr) m_ovr <= 1'b0;
      if (q.size() != 0 && out_ready) begin
        void'(q.pop_front());
        if (rx_valid) q.push_back(rx_data);
      end else if (rx_valid && q.size() < DEPTH) begin
        q.push_back(rx_data);
      end
    end
  end

  // Record what the DUT delivers on each handshake.
  always @(posedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready) popped.push_back(out_data);
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("level", 32'(level), 32'(q.size()));
      check("out_valid", 32'(out_valid), 32'(q.size() != 0));
      check("empty", 32'(empty), 32'(q.size() == 0));
      check("full", 32'(full), 32'(q.size() == DEPTH));
      check("overrun", 32'(overrun), 32'(m_ovr));
      if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
    end
  end

  // One clock cycle with the given inputs; returns shortly after the edge.
  task automatic cyc(input bit rv, input logic [7:0] d, input bit rdy, input bit clr);
    rx_valid = rv;
    rx_data = d;
    out_ready = rdy;
    overrun_clr = clr;
    @(posedge clk);
    #2;
    rx_valid = 1'b0;
    out_ready = 1'b0;
    overrun_clr = 1'b0;
  endtask

  initial begin
    int bad;
    // Reset, then idle.
    rst_n = 1'b0;
    cyc(0, 8'h00, 0, 0);
    cyc(0, 8'h00, 0, 0);
    chk_en = 1'b1;
    rst_n = 1'b1;
    repeat (5) cyc(0, 8'h00, 0, 0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Three pushes, then three pops in order.
    cyc(1, 8'h41, 0, 0);
    cyc(1, 8'h42, 0, 0);
    cyc(1, 8'h43, 0, 0);
    check("abc_level", 32'(level), 32'd3);
    check("abc_head", 32'(out_data), 32'h41);
    popped.delete();
    repeat (3) cyc(0, 8'h00, 1, 0);
    check("abc_count", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      check("abc_pop0", 32'(popped[0]), 32'h41);
      check("abc_pop1", 32'(popped[1]), 32'h42);
      check("abc_pop2", 32'(popped[2]), 32'h43);
    end
    check("abc_empty", 32'(empty), 32'd1);

    // Fill, overflow with 0xAA, drain.
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_level", 32'(level), 32'd16);
    cyc(1, 8'hAA, 0, 0);
    check("drop_overrun", 32'(overrun), 32'd1);
    check("drop_level", 32'(level), 32'd16);
    popped.delete();
    repeat (DEPTH) cyc(0, 8'h00, 1, 0);
    bad = 0;
    for (int i = 0; i < popped.size(); i++) if (popped[i] !== 8'(i)) bad++;
    check("drain_count", 32'(popped.size()), 32'd16);
    check("drain_order_errors", 32'(bad), 32'd0);
    check("drain_empty", 32'(empty), 32'd1);
    cyc(0, 8'h00, 0, 1);
    check("clr_overrun", 32'(overrun), 32'd0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0);
    popped.delete();
    cyc(1, 8'h55, 1, 0);
    check("sim_level", 32'(level), 32'd16);
    check("sim_overrun", 32'(overrun), 32'd0);
    repeat (DEPTH) cyc(0, 8'h00, 1, 0);
    check("sim_count", 32'(popped.size()), 32'd17);
    if (popped.size() == 17) begin
      check("sim_first", 32'(popped[0]), 32'h00);
      check("sim_last", 32'(popped[16]), 32'h55);
    end

    // Drop plus clear in the same cycle: set wins; clear alone then clears.
    for (int i = 0; i < DEPTH; i++) cyc(1, 8'(8'h80 + i), 0, 0);
    cyc(1, 8'hEE, 0, 0);
    check("ovr_set", 32'(overrun), 32'd1);
    cyc(1, 8'hEF, 0, 1);
    check("ovr_set_wins", 32'(overrun), 32'd1);
    cyc(0, 8'h00, 0, 1);
    check("ovr_cleared", 32'(overrun), 32'd0);
    repeat (DEPTH) cyc(0, 8'h00, 1, 0);
    check("ovr_drained", 32'(empty), 32'd1);

    // 40 pushes with interleaved random pops: pointers wrap twice.
    for (int i = 0; i < 40; i++) cyc(1, 8'($urandom), ($urandom_range(0, 3) != 0), 0);
    repeat (DEPTH + 4) cyc(0, 8'h00, 1, 0);
    check("wrap_empty", 32'(empty), 32'd1);

    // Free-running random traffic, including clears and overflow pressure.
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 1) == 1,
          $urandom_range(0, 15) == 0);
    repeat (DEPTH + 2) cyc(0, 8'h00, 1, 0);

    // Mid-stream reset with five bytes queued.
    cyc(0, 8'h00, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    check("pre_rst_level", 32'(level), 32'd5);
    rst_n = 1'b0;
    cyc(1, 8'h99, 1, 0);
    rst_n = 1'b1;
    check("post_rst_level", 32'(level), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    cyc(1, 8'h77, 0, 0);
    check("post_rst_head_valid", 32'(out_valid), 32'd1);
    check("post_rst_head", 32'(out_data), 32'h77);
    popped.delete();
    cyc(0, 8'h00, 1, 0);
    check("post_rst_pop_count", 32'(popped.size()), 32'd1);
    if (popped.size() == 1) check("post_rst_pop", 32'(popped[0]), 32'h77);
    cyc(0, 8'h00, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
